// File: rtl/coefficient_loader.sv
// Steps coefficient_num through each FIR coefficient and pulses load_coeff / clear_coeff.
// Optional: define COEFF_LOADER_ABORT_EN to abandon a set when new_coefficient_set drops mid-load.
module coefficient_loader #(
  parameter int unsigned NUM_COEFFS = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       new_coefficient_set,
  input  logic       modwait,
  output logic       load_coeff,
  output logic [1:0] coefficient_num,
  output logic       clear_coeff
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_COEFFS - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD0, SETTLE0, WAIT0,
    LOAD1, SETTLE1, WAIT1,
    LOAD2, SETTLE2, WAIT2,
    LOAD3, SETTLE3, WAIT3,
    DONE,
    RELEASE
  } state_t;

  state_t state;
  state_t state_n;
  logic   in_hold;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    in_hold = 1'b0;
    case (state)
      IDLE:    if (new_coefficient_set && !modwait) state_n = LOAD0;
      LOAD0:   state_n = SETTLE0;
      LOAD1:   state_n = SETTLE1;
      LOAD2:   state_n = SETTLE2;
      LOAD3:   state_n = SETTLE3;
      SETTLE0: begin state_n = WAIT0; in_hold = 1'b1; end
      SETTLE1: begin state_n = WAIT1; in_hold = 1'b1; end
      SETTLE2: begin state_n = WAIT2; in_hold = 1'b1; end
      SETTLE3: begin state_n = WAIT3; in_hold = 1'b1; end
      WAIT0: begin
        in_hold = 1'b1;
        if (!modwait) state_n = (coefficient_num == LAST_IDX) ? DONE : LOAD1;
      end
      WAIT1: begin
        in_hold = 1'b1;
        if (!modwait) state_n = (coefficient_num == LAST_IDX) ? DONE : LOAD2;
      end
      WAIT2: begin
        in_hold = 1'b1;
        if (!modwait) state_n = (coefficient_num == LAST_IDX) ? DONE : LOAD3;
      end
      WAIT3: begin
        in_hold = 1'b1;
        if (!modwait) state_n = DONE;
      end
      DONE:    state_n = RELEASE;
      RELEASE: if (!new_coefficient_set) state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef COEFF_LOADER_ABORT_EN
    // Abort overrides the normal step; LOAD states are excluded so a request always completes.
    if (in_hold && !new_coefficient_set) state_n = IDLE;
`endif
  end

  always_comb begin
    load_coeff      = 1'b0;
    clear_coeff     = 1'b0;
    coefficient_num = '0;
    case (state)
      LOAD0:                 load_coeff = 1'b1;
      LOAD1:   begin load_coeff = 1'b1; coefficient_num = 2'd1; end
      LOAD2:   begin load_coeff = 1'b1; coefficient_num = 2'd2; end
      LOAD3:   begin load_coeff = 1'b1; coefficient_num = 2'd3; end
      SETTLE1, WAIT1:        coefficient_num = 2'd1;
      SETTLE2, WAIT2:        coefficient_num = 2'd2;
      SETTLE3, WAIT3:        coefficient_num = 2'd3;
      DONE:                  clear_coeff = 1'b1;
      default:               coefficient_num = '0;
    endcase
  end

endmodule

// File: tb/tb_coefficient_loader.sv
// Self-checking bench for coefficient_loader: vector table, directed corner cases and
// randomized traffic against a cycle-level reference model.
module tb_coefficient_loader;

`ifdef COEFF_LOADER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  localparam int NUM = 4;

  logic       tb_clk = 1'b0;
  logic       n_rst;
  logic       new_coefficient_set;
  logic       modwait;
  logic       load_coeff;
  logic [1:0] coefficient_num;
  logic       clear_coeff;

  int vec_count  = 0;
  int miss_count = 0;

  coefficient_loader #(.NUM_COEFFS(4)) dut (
    .clk                 (tb_clk),
    .n_rst               (n_rst),
    .new_coefficient_set (new_coefficient_set),
    .modwait             (modwait),
    .load_coeff          (load_coeff),
    .coefficient_num     (coefficient_num),
    .clear_coeff         (clear_coeff)
  );

  always #5 tb_clk = ~tb_clk;

  // Reference model: mode 0 idle, 1 loading, 2 clearing, 3 waiting for the slave to drop the flag.
  // age counts cycles since the current coefficient's load request (saturates at 2).
  int m_mode = 0;
  int m_idx  = 0;
  int m_age  = 0;

  task automatic model_step(input logic s_ncs, input logic s_mw);
    case (m_mode)
      0: if (s_ncs && !s_mw) begin m_mode = 1; m_idx = 0; m_age = 0; end
      1: begin
        if (ABORT_EN && m_age >= 1 && !s_ncs) m_mode = 0;
        else if (m_age >= 2 && !s_mw) begin
          if (m_idx == NUM - 1) m_mode = 2;
          else begin m_idx = m_idx + 1; m_age = 0; end
        end else if (m_age < 2) m_age = m_age + 1;
      end
      2: m_mode = 3;
      default: if (!s_ncs) m_mode = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [7:0] act, input int exp);
    vec_count++;
    if (act !== exp[7:0]) begin
      miss_count++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_load",  {7'd0, load_coeff},  (m_mode == 1 && m_age == 0) ? 1 : 0);
    check("model_num",   {6'd0, coefficient_num}, (m_mode == 1) ? m_idx : 0);
    check("model_clear", {7'd0, clear_coeff}, (m_mode == 2) ? 1 : 0);
    check("exclusive",   {7'd0, load_coeff & clear_coeff}, 0);
  endtask

  // Called at a falling edge: drive inputs, advance one rising edge, check at the next falling edge.
  task automatic cyc(input logic a_ncs, input logic a_mw);
    new_coefficient_set = a_ncs;
    modwait             = a_mw;
    @(posedge tb_clk);
    model_step(a_ncs, a_mw);
    @(negedge tb_clk);
    check_model();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {5'd0, load_coeff, coefficient_num, clear_coeff} , 0);
  endtask

  typedef struct {
    logic ncs;
    logic mw;
    int   load;
    int   num;
    int   clear;
  } vec_t;

  vec_t tab [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int gap;
    int loads;
    int clears;

    // modwait=1 in rows 1,2,4,5 lands on LOAD/SETTLE and must be ignored.
    tab[0]  = '{1'b1, 1'b0, 1, 0, 0};
    tab[1]  = '{1'b1, 1'b1, 0, 0, 0};
    tab[2]  = '{1'b1, 1'b1, 0, 0, 0};
    tab[3]  = '{1'b1, 1'b0, 1, 1, 0};
    tab[4]  = '{1'b1, 1'b1, 0, 1, 0};
    tab[5]  = '{1'b1, 1'b1, 0, 1, 0};
    tab[6]  = '{1'b1, 1'b0, 1, 2, 0};
    tab[7]  = '{1'b1, 1'b0, 0, 2, 0};
    tab[8]  = '{1'b1, 1'b0, 0, 2, 0};
    tab[9]  = '{1'b1, 1'b0, 1, 3, 0};
    tab[10] = '{1'b1, 1'b0, 0, 3, 0};
    tab[11] = '{1'b1, 1'b0, 0, 3, 0};
    tab[12] = '{1'b1, 1'b0, 0, 0, 1};
    tab[13] = '{1'b1, 1'b0, 0, 0, 0};
    tab[14] = '{1'b0, 1'b0, 0, 0, 0};
    tab[15] = '{1'b0, 1'b0, 0, 0, 0};

    // Reset with inputs active
    n_rst = 1'b1;
    new_coefficient_set = 1'b1;
    modwait = 1'b1;
    #2 n_rst = 1'b0;
    #1 check_all_zero("reset_immediate");
    m_mode = 0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    check_all_zero("reset_held");
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      check("reset_no_load_while_busy", {7'd0, load_coeff}, 0);
    end
    cyc(1'b1, 1'b0);
    check("reset_first_load", {7'd0, load_coeff}, 1);
    check("reset_first_num", {6'd0, coefficient_num}, 0);
    gap = 0;
    while (!clear_coeff && gap < 20) begin cyc(1'b1, 1'b0); gap++; end
    check("reset_seq_clear", {7'd0, clear_coeff}, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Best-case table
    for (int i = 0; i < 16; i++) begin
      cyc(tab[i].ncs, tab[i].mw);
      check("tab_load",  {7'd0, load_coeff},       tab[i].load);
      check("tab_num",   {6'd0, coefficient_num},  tab[i].num);
      check("tab_clear", {7'd0, clear_coeff},      tab[i].clear);
    end

    // Controller stall: modwait high for 7 cycles after each load = 5 WAIT samples high
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("stall_load", {7'd0, load_coeff}, 1);
      check("stall_num", {6'd0, coefficient_num}, k);
      gap = 0;
      for (int j = 0; j < 7; j++) begin
        cyc(1'b1, 1'b1);
        gap++;
        check("stall_hold_num", {6'd0, coefficient_num}, k);
      end
      do begin
        cyc(1'b1, 1'b0);
        gap++;
      end while (!load_coeff && !clear_coeff && gap < 20);
      check("stall_gap", gap[7:0], 8);
    end
    check("stall_clear", {7'd0, clear_coeff}, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Slow clear
    cyc(1'b1, 1'b0);
    gap = 0;
    while (!clear_coeff && gap < 20) begin cyc(1'b1, 1'b0); gap++; end
    check("slow_clear_seen", {7'd0, clear_coeff}, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0);
      check("slow_no_reload", {7'd0, load_coeff | clear_coeff}, 0);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("slow_restart_load", {7'd0, load_coeff}, 1);
    check("slow_restart_num", {6'd0, coefficient_num}, 0);
    gap = 0;
    while (!clear_coeff && gap < 20) begin cyc(1'b1, 1'b0); gap++; end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);

    // Mid-sequence reset in WAIT2
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("midrst_in_wait2", {6'd0, coefficient_num}, 2);
    #2 n_rst = 1'b0;
    #1 check_all_zero("midrst_immediate");
    m_mode = 0;
    new_coefficient_set = 1'b0;
    modwait = 1'b0;
    @(negedge tb_clk);
    n_rst = 1'b1;
    clears = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 1'b0);
      if (clear_coeff) clears++;
    end
    check("midrst_no_clear", clears[7:0], 0);

    // Abort stimulus: drop the flag while in WAIT1
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("abort_in_wait1", {6'd0, coefficient_num}, 1);
    cyc(1'b0, 1'b1);
    check("abort_num_after_drop", {6'd0, coefficient_num}, ABORT_EN ? 0 : 1);
    loads = 0;
    clears = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0);
      if (load_coeff) loads++;
      if (clear_coeff) clears++;
    end
    check("abort_loads", loads[7:0], ABORT_EN ? 0 : 2);
    check("abort_clears", clears[7:0], ABORT_EN ? 0 : 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
